// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Mode encoding, 50 MHz divisor constants and a per-Hz divisor helper.
package clkdiv_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_TICK   = 1'b1
  } clk_mode_e;

  localparam int unsigned SYS_CLK_HZ        = 50_000_000;
  localparam int unsigned DEF_DIV_50MHZ_1HZ = 25_000_000;
  // Toggle divisor for 1 Hz; divide by the wanted rate in Hz.
  localparam int unsigned DIV_PER_HZ_50MHZ  = SYS_CLK_HZ / 2;

  function automatic int unsigned div_for_hz(
    input int unsigned hz
  );
    return (hz == 0) ? DIV_PER_HZ_50MHZ
                     : DIV_PER_HZ_50MHZ / hz;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadow/active config and registered outputs.
// Shadow config moves to active only at terminal count, disable or sync.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int          CNT_W   = 25,
  parameter int unsigned DEF_DIV = DEF_DIV_50MHZ_1HZ
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             mode_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] adiv_q, adiv_d;
  logic [CNT_W-1:0] sdiv_q, sdiv_d;
  logic             amode_q, amode_d;
  logic             smode_q, smode_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] dmax;
  logic             tc, stop, xfer;

  always_comb begin
    dmax    = (adiv_q == '0) ? CNT_W'(1) : adiv_q;
    tc      = (cnt_q == dmax - CNT_W'(1));
    stop    = !en_i || sync_i;
    cnt_d   = cnt_q;
    out_d   = out_q;
    tick_d  = tick_q;
    adiv_d  = adiv_q;
    amode_d = amode_q;
    sdiv_d  = sdiv_q;
    smode_d = smode_q;
    xfer    = 1'b0;
    if (wr_i) begin
      sdiv_d  = div_i;
      smode_d = mode_i;
    end
    unique case (1'b1)
      stop: begin
        cnt_d  = '0;
        out_d  = 1'b0;
        tick_d = 1'b0;
        xfer   = 1'b1;
      end
      (!stop && tc): begin
        cnt_d  = '0;
        tick_d = 1'b1;
        xfer   = 1'b1;
        if (amode_q == MODE_TOGGLE) out_d = ~out_q;
        if (smode_q == MODE_TICK)   out_d = 1'b0;
      end
      default: begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
      end
    endcase
    // A write on this edge only reaches the shadow; transfer uses the old one.
    if (xfer) begin
      adiv_d  = sdiv_q;
      amode_d = smode_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      adiv_q  <= RST_DIV;
      sdiv_q  <= RST_DIV;
      amode_q <= MODE_TOGGLE;
      smode_q <= MODE_TOGGLE;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      adiv_q  <= adiv_d;
      sdiv_q  <= sdiv_d;
      amode_q <= amode_d;
      smode_q <= smode_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_out_o = out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent programmable dividers sharing one config write port.
// Optional SYNC_START_EN adds sync_start to phase-align all enabled channels.
module multi_channel_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          CNT_W   = 25,
  parameter int unsigned DEF_DIV = DEF_DIV_50MHZ_1HZ,
  parameter int          CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef SYNC_START_EN
  input  logic              sync_start,
`endif
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic sync_w;

`ifdef SYNC_START_EN
  assign sync_w = sync_start;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range cfg_ch matches no channel, so the write is dropped.
    logic wr;
    assign wr = cfg_we && (cfg_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (ch_en[i]),
      .sync_i    (sync_w),
      .wr_i      (wr),
      .div_i     (cfg_div),
      .mode_i    (cfg_mode),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Bench: directed and random stimulus checked against a period-level model.
// The model counts elapsed cycles per period and flips a level per period.
module tb_multi_channel_clock_divider;

  localparam int NC = 3;
  localparam int CW = 8;
  localparam int DD = 7;
  localparam int HW = 2;

  logic          clk;
  logic          reset_n;
  logic          cfg_we;
  logic [HW-1:0] cfg_ch;
  logic [CW-1:0] cfg_div;
  logic          cfg_mode;
  logic [NC-1:0] ch_en;
  logic [NC-1:0] clk_out;
  logic [NC-1:0] tick;
`ifdef SYNC_START_EN
  logic          sync_start;
`endif

  multi_channel_clock_divider #(
    .NUM_CH  (NC),
    .CNT_W   (CW),
    .DEF_DIV (DD),
    .CH_W    (HW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
`ifdef SYNC_START_EN
    .sync_start (sync_start),
`endif
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .ch_en    (ch_en),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  int elapsed [NC];
  int adiv    [NC];
  int sdiv    [NC];
  bit amode   [NC];
  bit smode   [NC];
  bit lvl     [NC];
  bit tk      [NC];
  logic [NC-1:0] ex_clk, ex_tick;

  task automatic chk(input string tag,
                     input logic [NC-1:0] obs,
                     input logic [NC-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      elapsed[i] = 0;
      adiv[i]    = DD;
      sdiv[i]    = DD;
      amode[i]   = 1'b0;
      smode[i]   = 1'b0;
      lvl[i]     = 1'b0;
      tk[i]      = 1'b0;
    end
  endtask

  task automatic model_step();
    bit s;
    s = 1'b0;
`ifdef SYNC_START_EN
    s = sync_start;
`endif
    for (int i = 0; i < NC; i++) begin
      int  od, per;
      bit  om;
      od  = sdiv[i];
      om  = smode[i];
      per = (adiv[i] == 0) ? 1 : adiv[i];
      if (cfg_we && int'(cfg_ch) == i) begin
        sdiv[i]  = int'(cfg_div);
        smode[i] = cfg_mode;
      end
      if (!ch_en[i] || s) begin
        elapsed[i] = 0;
        lvl[i]     = 1'b0;
        tk[i]      = 1'b0;
        adiv[i]    = od;
        amode[i]   = om;
      end else begin
        elapsed[i]++;
        if (elapsed[i] == per) begin
          elapsed[i] = 0;
          tk[i]      = 1'b1;
          if (!amode[i]) lvl[i] = !lvl[i];
          if (om)        lvl[i] = 1'b0;
          adiv[i]    = od;
          amode[i]   = om;
        end else begin
          tk[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < NC; i++) begin
      ex_clk[i]  = lvl[i];
      ex_tick[i] = tk[i];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("clk_out", clk_out, ex_clk);
    chk("tick", tick, ex_tick);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wr(input int ch, input int dv, input bit md);
    cfg_we   = 1'b1;
    cfg_ch   = HW'(ch);
    cfg_div  = CW'(dv);
    cfg_mode = md;
    cyc();
    cfg_we   = 1'b0;
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    reset_n  = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_mode = 1'b0;
    ch_en    = '0;
`ifdef SYNC_START_EN
    sync_start = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_clk_out", clk_out, '0);
    chk("reset_tick", tick, '0);
    reset_n = 1'b1;

    // ch0 toggle at div 5, first tick 5 cycles after enable
    wr(0, 5, 1'b0);
    cyc();
    ch_en = 3'b001;
    run(4);
    chk("first_tick_wait", tick, 3'b000);
    cyc();
    chk("first_tick", tick, 3'b001);
    run(20);

    // ch1 tick mode div 3
    wr(1, 3, 1'b1);
    cyc();
    ch_en = 3'b011;
    run(12);

    // ch0 div 8, then div 2 mid-period
    wr(0, 8, 1'b0);
    run(14);
    wr(0, 2, 1'b0);
    run(20);

    // div 0 / 1 in tick mode, div 1 in toggle mode
    wr(2, 0, 1'b1);
    wr(1, 1, 1'b1);
    wr(0, 1, 1'b0);
    cyc();
    ch_en = 3'b111;
    run(6);
    chk("div0_tick_high", tick & 3'b110, 3'b110);
    run(4);

    // asynchronous reset mid-period
    wr(0, 8, 1'b0);
    run(12);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_clk_out", clk_out, '0);
    chk("async_tick", tick, '0);
    model_reset();
    @(posedge clk);
    #1;
    ch_en   = 3'b001;
    reset_n = 1'b1;
    run(16);

    // out-of-range channel write is ignored
    ch_en = 3'b111;
    run(3);
    wr(3, 1, 1'b1);
    run(16);

`ifdef SYNC_START_EN
    wr(0, 4, 1'b0);
    wr(1, 6, 1'b1);
    run(9);
    sync_start = 1'b1;
    cyc();
    sync_start = 1'b0;
    run(14);
`endif

    for (int k = 0; k < 500; k++) begin
      cfg_we   = ($urandom_range(3) == 0);
      cfg_ch   = HW'($urandom_range(3));
      cfg_div  = CW'($urandom_range(9));
      cfg_mode = $urandom_range(1);
      for (int i = 0; i < NC; i++)
        if ($urandom_range(15) == 0) ch_en[i] = ~ch_en[i];
`ifdef SYNC_START_EN
      sync_start = ($urandom_range(19) == 0);
`endif
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
